// File: rtl/rvvi_retire_arbiter.sv
// -----------------------------------------------------------------------------
// rvvi_retire_arbiter
//
// Shares one single-event trace consumer between NHART harts, each retiring up
// to RETIRE instructions per cycle. Every hart owns a slot bank. A retire
// bundle is captured whole when the bank is empty. Banks are then drained
// round-robin across harts, one event per cycle, lowest slot first.
//
// Optional feature macro: RVVI_ARB_ORDER_CHECK_EN
//   defined   -> per-hart order continuity check drives the sticky order_err
//   undefined -> no checker state, order_err tied low
//
// Ports
//   clk        in   interface clock, all state on posedge
//   reset_n    in   asynchronous active-low reset
//   in_valid   in   [NHART*RETIRE]       slot valid, index h*RETIRE+r
//   in_order   in   [NHART*RETIRE*64]    event order per slot
//   in_insn    in   [NHART*RETIRE*ILEN]  instruction per slot
//   in_pc      in   [NHART*RETIRE*XLEN]  pc_rdata per slot
//   in_trap    in   [NHART*RETIRE]       trap flag per slot
//   in_ready   out  [NHART]              bank empty, a bundle is taken this cycle
//   out_valid  out  output register holds an event
//   out_ready  in   consumer accepts the event
//   out_hart   out  [HW]   source hart of the event
//   out_slot   out  [SW]   source slot of the event
//   out_order  out  [64]   event order
//   out_insn   out  [ILEN] instruction
//   out_pc     out  [XLEN] pc_rdata
//   out_trap   out  trap flag
//   order_err  out  [NHART] sticky per-hart order-gap flag
// -----------------------------------------------------------------------------
module rvvi_retire_arbiter #(
   parameter int NHART  = 1,
   parameter int RETIRE = 1,
   parameter int XLEN   = 32,
   parameter int ILEN   = 32,
   parameter int HW     = $clog2(NHART > 1 ? NHART : 2),
   parameter int SW     = $clog2(RETIRE > 1 ? RETIRE : 2)
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [NHART*RETIRE-1:0]      in_valid,
   input  logic [NHART*RETIRE*64-1:0]   in_order,
   input  logic [NHART*RETIRE*ILEN-1:0] in_insn,
   input  logic [NHART*RETIRE*XLEN-1:0] in_pc,
   input  logic [NHART*RETIRE-1:0]      in_trap,
   output logic [NHART-1:0]             in_ready,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [HW-1:0]                out_hart,
   output logic [SW-1:0]                out_slot,
   output logic [63:0]                  out_order,
   output logic [ILEN-1:0]              out_insn,
   output logic [XLEN-1:0]              out_pc,
   output logic                         out_trap,
   output logic [NHART-1:0]             order_err
);

   localparam int NS = NHART * RETIRE;

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_DRAIN = 1'b1
   } state_t;

   // Slot banks and pending masks (flat index h*RETIRE+r)
   logic [NS-1:0]   pend_q;
   logic [NS-1:0]   pend_d;
   logic [63:0]     bank_order_q [NS];
   logic [ILEN-1:0] bank_insn_q  [NS];
   logic [XLEN-1:0] bank_pc_q    [NS];
   logic [NS-1:0]   bank_trap_q;

   // Arbiter state and output register
   state_t          state_q;
   logic [HW-1:0]   grant_q;
   logic [HW-1:0]   last_q;
   logic            out_valid_q;
   logic [HW-1:0]   out_hart_q;
   logic [SW-1:0]   out_slot_q;
   logic [63:0]     out_order_q;
   logic [ILEN-1:0] out_insn_q;
   logic [XLEN-1:0] out_pc_q;
   logic            out_trap_q;

   // Combinational helpers
   logic [NHART-1:0]  in_ready_s;
   logic [NHART-1:0]  cap_s;
   logic              any_pend_s;
   logic [HW-1:0]     nxt_grant_s;
   logic              found_s;
   logic [RETIRE-1:0] gpend_s;
   logic [RETIRE-1:0] sel_hot_s;
   logic [SW-1:0]     sel_slot_s;
   logic              sel_hit_s;
   int                sel_flat_s;
   logic              load_s;
   logic              done_s;
   logic [NS-1:0]     clr_s;
   logic [63:0]       sel_order_s;
   logic [ILEN-1:0]   sel_insn_s;
   logic [XLEN-1:0]   sel_pc_s;
   logic              sel_trap_s;

   // Per-hart ready (bank empty) and capture qualifiers
   always_comb begin
      in_ready_s = '0;
      cap_s      = '0;
      any_pend_s = |pend_q;
      for (int h = 0; h < NHART; h++) begin
         in_ready_s[h] = ~|pend_q[h*RETIRE +: RETIRE];
         cap_s[h]      = in_ready_s[h] & (|in_valid[h*RETIRE +: RETIRE]);
      end
   end

   assign in_ready = in_ready_s;

   // Round-robin search: harts above last first, then wrap to 0..last
   always_comb begin
      nxt_grant_s = '0;
      found_s     = 1'b0;
      for (int h = 0; h < NHART; h++) begin
         if (!found_s && (h > int'(last_q)) && (|pend_q[h*RETIRE +: RETIRE])) begin
            found_s     = 1'b1;
            nxt_grant_s = HW'(h);
         end else begin
            found_s = found_s;
         end
      end
      for (int h = 0; h < NHART; h++) begin
         if (!found_s && (h <= int'(last_q)) && (|pend_q[h*RETIRE +: RETIRE])) begin
            found_s     = 1'b1;
            nxt_grant_s = HW'(h);
         end else begin
            found_s = found_s;
         end
      end
   end

   // Lowest pending slot of the granted hart and the bank entry it selects
   always_comb begin
      gpend_s = '0;
      for (int h = 0; h < NHART; h++) begin
         if (HW'(h) == grant_q) begin
            gpend_s = pend_q[h*RETIRE +: RETIRE];
         end else begin
            gpend_s = gpend_s;
         end
      end

      sel_slot_s = '0;
      sel_hot_s  = '0;
      sel_hit_s  = 1'b0;
      for (int r = 0; r < RETIRE; r++) begin
         if (!sel_hit_s && gpend_s[r]) begin
            sel_hit_s    = 1'b1;
            sel_slot_s   = SW'(r);
            sel_hot_s[r] = 1'b1;
         end else begin
            sel_hit_s = sel_hit_s;
         end
      end

      // The output register can take a new event when empty or being drained
      load_s     = (state_q == S_DRAIN) && (!out_valid_q || out_ready);
      done_s     = load_s && ~|(gpend_s & ~sel_hot_s);
      sel_flat_s = int'(grant_q) * RETIRE + int'(sel_slot_s);

      sel_order_s = '0;
      sel_insn_s  = '0;
      sel_pc_s    = '0;
      sel_trap_s  = 1'b0;
      clr_s       = '0;
      for (int i = 0; i < NS; i++) begin
         if (i == sel_flat_s) begin
            sel_order_s = bank_order_q[i];
            sel_insn_s  = bank_insn_q[i];
            sel_pc_s    = bank_pc_q[i];
            sel_trap_s  = bank_trap_q[i];
            clr_s[i]    = load_s;
         end else begin
            clr_s[i] = 1'b0;
         end
      end
   end

   // Next pending mask: capture only happens into an empty bank, so it never
   // collides with a clear of the same hart
   always_comb begin
      pend_d = pend_q;
      for (int h = 0; h < NHART; h++) begin
         for (int r = 0; r < RETIRE; r++) begin
            pend_d[h*RETIRE+r] = cap_s[h] ? in_valid[h*RETIRE+r]
                                          : (pend_q[h*RETIRE+r] & ~clr_s[h*RETIRE+r]);
         end
      end
   end

   // Pending mask and slot bank capture
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_q      <= '0;
         bank_trap_q <= '0;
         for (int i = 0; i < NS; i++) begin
            bank_order_q[i] <= '0;
            bank_insn_q[i]  <= '0;
            bank_pc_q[i]    <= '0;
         end
      end else begin
         pend_q <= pend_d;
         for (int h = 0; h < NHART; h++) begin
            if (cap_s[h]) begin
               for (int r = 0; r < RETIRE; r++) begin
                  bank_order_q[h*RETIRE+r] <= in_order[(h*RETIRE+r)*64 +: 64];
                  bank_insn_q[h*RETIRE+r]  <= in_insn[(h*RETIRE+r)*ILEN +: ILEN];
                  bank_pc_q[h*RETIRE+r]    <= in_pc[(h*RETIRE+r)*XLEN +: XLEN];
                  bank_trap_q[h*RETIRE+r]  <= in_trap[h*RETIRE+r];
               end
            end
         end
      end
   end

   // Arbiter FSM with registered event output
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         grant_q     <= '0;
         last_q      <= HW'(NHART - 1);
         out_valid_q <= 1'b0;
         out_hart_q  <= '0;
         out_slot_q  <= '0;
         out_order_q <= '0;
         out_insn_q  <= '0;
         out_pc_q    <= '0;
         out_trap_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (any_pend_s) begin
                  grant_q <= nxt_grant_s;
                  state_q <= S_DRAIN;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_DRAIN: begin
               if (done_s) begin
                  last_q  <= grant_q;
                  state_q <= S_IDLE;
               end else begin
                  state_q <= S_DRAIN;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase

         if (load_s) begin
            out_valid_q <= 1'b1;
            out_hart_q  <= grant_q;
            out_slot_q  <= sel_slot_s;
            out_order_q <= sel_order_s;
            out_insn_q  <= sel_insn_s;
            out_pc_q    <= sel_pc_s;
            out_trap_q  <= sel_trap_s;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end else begin
            out_valid_q <= out_valid_q;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_hart  = out_hart_q;
   assign out_slot  = out_slot_q;
   assign out_order = out_order_q;
   assign out_insn  = out_insn_q;
   assign out_pc    = out_pc_q;
   assign out_trap  = out_trap_q;

`ifdef RVVI_ARB_ORDER_CHECK_EN
   logic [NHART-1:0] seen_q;
   logic [63:0]      exp_q [NHART];
   logic [NHART-1:0] order_err_q;

   // Order continuity: every loaded event must follow the previous one of
   // the same hart by exactly one (64-bit wrap allowed)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         seen_q      <= '0;
         order_err_q <= '0;
         for (int h = 0; h < NHART; h++) begin
            exp_q[h] <= '0;
         end
      end else begin
         for (int h = 0; h < NHART; h++) begin
            if (load_s && (HW'(h) == grant_q)) begin
               if (seen_q[h] && (sel_order_s != exp_q[h])) begin
                  order_err_q[h] <= 1'b1;
               end
               exp_q[h]  <= sel_order_s + 64'd1;
               seen_q[h] <= 1'b1;
            end
         end
      end
   end

   assign order_err = order_err_q;
`else
   assign order_err = '0;
`endif

endmodule

// File: tb/tb_rvvi_retire_arbiter.sv
module tb_rvvi_retire_arbiter;

   localparam int NH = 2;
   localparam int RT = 2;
   localparam int NS = NH * RT;

`ifdef RVVI_ARB_ORDER_CHECK_EN
   localparam logic [63:0] GAP_ERR = 64'd1;
`else
   localparam logic [63:0] GAP_ERR = 64'd0;
`endif

   typedef struct packed {
      logic [0:0]  hart;
      logic [0:0]  slot;
      logic [63:0] order;
      logic [31:0] insn;
      logic [31:0] pc;
      logic        trap;
   } ev_t;

   logic           clk;
   logic           reset_n;
   logic [NS-1:0]  in_valid;
   logic [NS*64-1:0] in_order;
   logic [NS*32-1:0] in_insn;
   logic [NS*32-1:0] in_pc;
   logic [NS-1:0]  in_trap;
   logic [NH-1:0]  in_ready;
   logic           out_valid;
   logic           out_ready;
   logic [0:0]     out_hart;
   logic [0:0]     out_slot;
   logic [63:0]    out_order;
   logic [31:0]    out_insn;
   logic [31:0]    out_pc;
   logic           out_trap;
   logic [NH-1:0]  order_err;

   ev_t sb [$];
   int  n_cmp = 0;
   int  n_err = 0;

   rvvi_retire_arbiter #(
      .NHART (NH),
      .RETIRE(RT),
      .XLEN  (32),
      .ILEN  (32)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_valid (in_valid),
      .in_order (in_order),
      .in_insn  (in_insn),
      .in_pc    (in_pc),
      .in_trap  (in_trap),
      .in_ready (in_ready),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_hart (out_hart),
      .out_slot (out_slot),
      .out_order(out_order),
      .out_insn (out_insn),
      .out_pc   (out_pc),
      .out_trap (out_trap),
      .order_err(order_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to the next cycle, sampling/driving 2 time units after the edge
   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_in();
      in_valid = '0;
      in_order = '0;
      in_insn  = '0;
      in_pc    = '0;
      in_trap  = '0;
   endtask

   // Place one slot on the inputs; optionally record the event it must produce
   task automatic put_slot(input int h, input int r, input logic [63:0] ord, input bit push);
      int  i;
      ev_t e;
      i = h * RT + r;
      in_valid[i]          = 1'b1;
      in_order[i*64 +: 64] = ord;
      in_insn[i*32 +: 32]  = ord[31:0] ^ 32'h1357_9BDF;
      in_pc[i*32 +: 32]    = {ord[29:0], 2'b00};
      in_trap[i]           = ord[0];
      if (push) begin
         e.hart  = 1'(h);
         e.slot  = 1'(r);
         e.order = ord;
         e.insn  = ord[31:0] ^ 32'h1357_9BDF;
         e.pc    = {ord[29:0], 2'b00};
         e.trap  = ord[0];
         sb.push_back(e);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd3);
      chk("rst_order_err", 64'(order_err), 64'd0);
      next_cycle();
      reset_n = 1'b1;
      next_cycle();
   endtask

   // Scoreboard: every accepted event must match the oldest expected one
   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_event", 64'(out_order), 64'hDEAD_DEAD_DEAD_DEAD);
         end else begin
            ev_t e;
            e = sb.pop_front();
            chk("sb_hart", 64'(out_hart), 64'(e.hart));
            chk("sb_slot", 64'(out_slot), 64'(e.slot));
            chk("sb_order", out_order, e.order);
            chk("sb_insn", 64'(out_insn), 64'(e.insn));
            chk("sb_pc", 64'(out_pc), 64'(e.pc));
            chk("sb_trap", 64'(out_trap), 64'(e.trap));
         end
      end
   end

   initial begin
      reset_n   = 1'b0;
      out_ready = 1'b1;
      clear_in();
      next_cycle();
      next_cycle();
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd3);
      chk("reset_out_order", out_order, 64'd0);
      chk("reset_out_insn", 64'(out_insn), 64'd0);
      chk("reset_out_pc", 64'(out_pc), 64'd0);
      chk("reset_out_hart", 64'(out_hart), 64'd0);
      chk("reset_order_err", 64'(order_err), 64'd0);
      reset_n = 1'b1;
      next_cycle();

      // Two-slot bundle from hart0: events at cycles 3 and 4
      put_slot(0, 0, 64'd5, 1'b1);
      put_slot(0, 1, 64'd6, 1'b1);
      next_cycle();
      clear_in();
      chk("t1_busy_in_ready0", 64'(in_ready[0]), 64'd0);
      next_cycle();
      chk("t1_c2_valid", 64'(out_valid), 64'd0);
      next_cycle();
      chk("t1_c3_valid", 64'(out_valid), 64'd1);
      chk("t1_c3_slot", 64'(out_slot), 64'd0);
      chk("t1_c3_order", out_order, 64'd5);
      next_cycle();
      chk("t1_c4_valid", 64'(out_valid), 64'd1);
      chk("t1_c4_slot", 64'(out_slot), 64'd1);
      chk("t1_c4_order", out_order, 64'd6);
      next_cycle();
      chk("t1_c5_in_ready0", 64'(in_ready[0]), 64'd1);
      chk("t1_c5_valid", 64'(out_valid), 64'd0);

      // Fairness after reset (last = hart1): hart0, bubble, hart1, then again
      do_reset();
      put_slot(0, 0, 64'd100, 1'b1);
      put_slot(1, 0, 64'd200, 1'b1);
      next_cycle();
      clear_in();
      next_cycle();
      next_cycle();
      chk("t2_c3_valid", 64'(out_valid), 64'd1);
      chk("t2_c3_hart", 64'(out_hart), 64'd0);
      next_cycle();
      chk("t2_c4_bubble", 64'(out_valid), 64'd0);
      next_cycle();
      chk("t2_c5_valid", 64'(out_valid), 64'd1);
      chk("t2_c5_hart", 64'(out_hart), 64'd1);
      chk("t2_c5_order", out_order, 64'd200);
      next_cycle();
      put_slot(0, 0, 64'd101, 1'b1);
      put_slot(1, 0, 64'd201, 1'b1);
      next_cycle();
      clear_in();
      next_cycle();
      next_cycle();
      chk("t2b_c3_hart", 64'(out_hart), 64'd0);
      chk("t2b_c3_order", out_order, 64'd101);
      next_cycle();
      chk("t2b_c4_bubble", 64'(out_valid), 64'd0);
      next_cycle();
      chk("t2b_c5_hart", 64'(out_hart), 64'd1);
      chk("t2b_c5_order", out_order, 64'd201);
      next_cycle();

      // Back-pressure: event held stable for 10 cycles, nothing lost
      out_ready = 1'b0;
      put_slot(0, 0, 64'd102, 1'b1);
      put_slot(0, 1, 64'd103, 1'b1);
      next_cycle();
      clear_in();
      next_cycle();
      next_cycle();
      chk("t3_c3_valid", 64'(out_valid), 64'd1);
      for (int k = 0; k < 10; k++) begin
         next_cycle();
         chk("t3_hold_valid", 64'(out_valid), 64'd1);
         chk("t3_hold_order", out_order, 64'd102);
         chk("t3_hold_in_ready0", 64'(in_ready[0]), 64'd0);
      end
      out_ready = 1'b1;
      next_cycle();
      chk("t3_rel_valid", 64'(out_valid), 64'd1);
      chk("t3_rel_order", out_order, 64'd103);
      next_cycle();
      chk("t3_done_valid", 64'(out_valid), 64'd0);
      chk("t3_done_in_ready0", 64'(in_ready[0]), 64'd1);

      // Sparse bundle: only slot1 valid
      put_slot(0, 1, 64'd104, 1'b1);
      next_cycle();
      clear_in();
      next_cycle();
      next_cycle();
      chk("t4_c3_valid", 64'(out_valid), 64'd1);
      chk("t4_c3_slot", 64'(out_slot), 64'd1);
      chk("t4_c3_order", out_order, 64'd104);
      next_cycle();
      chk("t4_c4_valid", 64'(out_valid), 64'd0);

      // Order check: gap 7 -> 9, sticky afterwards
      do_reset();
      put_slot(0, 0, 64'd7, 1'b1);
      put_slot(0, 1, 64'd9, 1'b1);
      next_cycle();
      clear_in();
      next_cycle();
      next_cycle();
      chk("t5_c3_err", 64'(order_err), 64'd0);
      next_cycle();
      chk("t5_c4_err", 64'(order_err), GAP_ERR);
      next_cycle();
      next_cycle();
      put_slot(0, 0, 64'd10, 1'b1);
      put_slot(0, 1, 64'd11, 1'b1);
      next_cycle();
      clear_in();
      repeat (4) next_cycle();
      chk("t5_sticky_err", 64'(order_err), GAP_ERR);

      // Contiguous orders and 64-bit wrap raise nothing
      do_reset();
      put_slot(0, 0, 64'd8, 1'b1);
      put_slot(0, 1, 64'd9, 1'b1);
      next_cycle();
      clear_in();
      repeat (5) next_cycle();
      chk("t5_contig_err", 64'(order_err), 64'd0);
      put_slot(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      put_slot(1, 1, 64'd0, 1'b1);
      next_cycle();
      clear_in();
      repeat (5) next_cycle();
      chk("t5_wrap_err", 64'(order_err), 64'd0);

      // Reset in the middle of a drain discards everything
      out_ready = 1'b0;
      put_slot(0, 0, 64'd50, 1'b0);
      put_slot(0, 1, 64'd51, 1'b0);
      put_slot(1, 0, 64'd60, 1'b0);
      next_cycle();
      clear_in();
      next_cycle();
      next_cycle();
      chk("t6_pre_valid", 64'(out_valid), 64'd1);
      #1;
      reset_n = 1'b0;
      #1;
      chk("t6_rst_valid", 64'(out_valid), 64'd0);
      chk("t6_rst_in_ready", 64'(in_ready), 64'd3);
      chk("t6_rst_order", out_order, 64'd0);
      next_cycle();
      reset_n   = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         next_cycle();
         chk("t6_no_stale", 64'(out_valid), 64'd0);
      end

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
